// File: rtl/shift_seq_pkg.sv
// Shared types and default parameters for the shift sequencer and its arbiter.
package shift_seq_pkg;

    localparam int NBITS_DEF = 32;
    localparam int STEP_DEF  = 3;
    localparam int AMT_W_DEF = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef logic id_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone request wins outright, a tie goes to the
// requester that did not win last time.
module rr_arb2
    import shift_seq_pkg::*;
(
    input  logic [1:0] req_i,
    input  id_t        last_grant_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o = req_i;
        if (req_i == 2'b11) begin
            gnt_o = (last_grant_i == 1'b1) ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle logical left shifter built from a fixed STEP-bit stage and a
// 1-bit stage, shared between two requesters via round-robin arbitration.
module shift_sequencer
    import shift_seq_pkg::*;
#(
    parameter int NBITS = NBITS_DEF,
    parameter int STEP  = STEP_DEF,
    parameter int AMT_W = AMT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_valid,
    input  logic [NBITS-1:0] req0_data,
    input  logic [AMT_W-1:0] req0_amt,
    input  logic [NBITS-1:0] req1_data,
    input  logic [AMT_W-1:0] req1_amt,
    output logic [1:0]       req_ready,
    output logic             out_valid,
    output logic [NBITS-1:0] out_data,
    output logic             out_id,
    input  logic             out_ready,
    output logic             busy,
    output state_t           dbg_state
);

    // Handshake: a request transfers on a rising edge where req_valid[i] and
    // req_ready[i] are both high; a result transfers where out_valid and
    // out_ready are both high. req_ready is only ever raised in IDLE.

    state_t           state_q, state_d;
    logic [NBITS-1:0] acc_q, acc_d;
    logic [AMT_W-1:0] rem_q, rem_d;
    id_t              out_id_q, out_id_d;
    id_t              last_grant_q, last_grant_d;

    logic [1:0]       gnt;
    logic [NBITS-1:0] sel_data;
    logic [AMT_W-1:0] sel_amt;
    id_t              sel_id;
    logic [NBITS-1:0] acc_coarse;
    logic [NBITS-1:0] acc_fine;

    rr_arb2 u_arb (
        .req_i        (req_valid),
        .last_grant_i (last_grant_q),
        .gnt_o        (gnt)
    );

    assign sel_id     = id_t'(gnt[1]);
    assign sel_data   = gnt[1] ? req1_data : req0_data;
    assign sel_amt    = gnt[1] ? req1_amt  : req0_amt;
    assign acc_coarse = acc_q << STEP;
    assign acc_fine   = acc_q << 1;

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        rem_d        = rem_q;
        out_id_d     = out_id_q;
        last_grant_d = last_grant_q;
        req_ready    = 2'b00;
        case (state_q)
            IDLE: begin
                req_ready = gnt;
                if (|gnt) begin
                    acc_d        = sel_data;
                    rem_d        = sel_amt;
                    out_id_d     = sel_id;
                    last_grant_d = sel_id;
                    if (sel_amt == '0) begin
                        state_d = DONE;
                    end else if (int'(sel_amt) >= NBITS) begin
                        // Everything shifts out; skip the walk entirely.
                        acc_d   = '0;
                        rem_d   = '0;
                        state_d = DONE;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                if (int'(rem_q) >= STEP) begin
                    acc_d = acc_coarse;
                    rem_d = rem_q - AMT_W'(STEP);
                end else begin
                    acc_d = acc_fine;
                    rem_d = rem_q - AMT_W'(1);
                end
                if (rem_d == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            acc_q        <= '0;
            rem_q        <= '0;
            out_id_q     <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            rem_q        <= rem_d;
            out_id_q     <= out_id_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign out_valid = (state_q == DONE);
    assign out_data  = out_valid ? acc_q : '0;
    assign out_id    = out_id_q;
    assign busy      = (state_q != IDLE);
    assign dbg_state = state_q;

endmodule
